// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-atomic arbiter for the UART TX FIFO write port.
// Ports: clock/reset; per-requester req_valid/req_data/req_last/req_ready;
//        uart_tx_fifo_data/write/full; grant, busy, overlong_error, stall_error.
module uart_tx_arbiter #(
    parameter int NUM_REQ     = 3,
    parameter int MAX_MSG_LEN = 16,
    parameter int STALL_LIMIT = 64
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             uart_tx_fifo_data,
    output logic                   uart_tx_fifo_write,
    input  logic                   uart_tx_fifo_full,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   overlong_error,
    output logic                   stall_error
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int BC_W  = $clog2(MAX_MSG_LEN + 1);
    localparam int SC_W  = $clog2(STALL_LIMIT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_XFER = 1'b1;

    logic [0:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDX_W-1:0]   r_gidx;
    logic [IDX_W-1:0]   r_last_owner;
    logic [BC_W-1:0]    r_byte_cnt;
    logic [SC_W-1:0]    r_stall_cnt;
    logic               r_ovl_err;
    logic               r_stall_err;

    logic               w_found;
    logic [IDX_W-1:0]   w_pick;
    logic [IDX_W:0]     w_cand;
    logic               w_own_valid;
    logic               w_own_last;
    logic               w_accept;
    logic               w_byte_lim;
    logic               w_stall_lim;
    logic               w_rel_last;
    logic               w_rel_ovl;
    logic               w_rel_stall;
    logic               w_release;

    // Cyclic scan starting just after the previous owner; the extra bit
    // of w_cand holds the unwrapped sum before folding back into range.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_cand = {1'b0, r_last_owner} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            if (!w_found && req_valid[w_cand[IDX_W-1:0]]) begin
                w_found = 1'b1;
                w_pick  = w_cand[IDX_W-1:0];
            end
        end
    end

    // Grant is zero outside XFER, so all datapath outputs idle at zero.
    assign req_ready   = r_grant & req_valid & {NUM_REQ{~uart_tx_fifo_full}};
    assign w_own_valid = |(r_grant & req_valid);
    assign w_own_last  = |(r_grant & req_last);
    assign w_accept    = |req_ready;

    always_comb begin
        uart_tx_fifo_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            uart_tx_fifo_data = uart_tx_fifo_data
                              | (req_data[8*i +: 8] & {8{r_grant[i]}});
        end
    end

    assign uart_tx_fifo_write = w_accept;
    assign grant              = r_grant;
    assign busy               = (r_state == S_XFER);
    assign overlong_error     = r_ovl_err;
    assign stall_error        = r_stall_err;

    assign w_byte_lim  = (r_byte_cnt + BC_W'(1)) == BC_W'(MAX_MSG_LEN);
    assign w_stall_lim = (r_stall_cnt + SC_W'(1)) == SC_W'(STALL_LIMIT);

    // Backpressure (owner valid, FIFO full) matches none of these terms,
    // so both counters simply hold.
    assign w_rel_last  = w_accept & w_own_last;
    assign w_rel_ovl   = w_accept & ~w_own_last & w_byte_lim;
    assign w_rel_stall = ~w_own_valid & w_stall_lim;
    assign w_release   = busy & (w_rel_last | w_rel_ovl | w_rel_stall);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_gidx       <= '0;
            r_last_owner <= IDX_W'(NUM_REQ - 1);
            r_byte_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_ovl_err    <= 1'b0;
            r_stall_err  <= 1'b0;
        end else begin
            r_ovl_err   <= busy & w_rel_ovl;
            r_stall_err <= busy & w_rel_stall;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_state <= S_XFER;
                        r_grant <= NUM_REQ'(1) << w_pick;
                        r_gidx  <= w_pick;
                    end
                end
                S_XFER: begin
                    if (w_release) begin
                        r_state      <= S_IDLE;
                        r_grant      <= '0;
                        r_last_owner <= r_gidx;
                        r_byte_cnt   <= '0;
                        r_stall_cnt  <= '0;
                    end else if (w_accept) begin
                        r_byte_cnt  <= r_byte_cnt + BC_W'(1);
                        r_stall_cnt <= '0;
                    end else if (!w_own_valid) begin
                        r_stall_cnt <= r_stall_cnt + SC_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues drive
// the DUT, expected FIFO writes are queued and checked by a monitor.
module tb_uart_tx_arbiter;

    localparam int N = 3;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     uart_tx_fifo_data;
    logic           uart_tx_fifo_write;
    logic           uart_tx_fifo_full = 1'b0;
    logic [N-1:0]   grant;
    logic           busy;
    logic           overlong_error;
    logic           stall_error;

    uart_tx_arbiter #(
        .NUM_REQ    (N),
        .MAX_MSG_LEN(16),
        .STALL_LIMIT(64)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_data          (req_data),
        .req_last          (req_last),
        .req_ready         (req_ready),
        .uart_tx_fifo_data (uart_tx_fifo_data),
        .uart_tx_fifo_write(uart_tx_fifo_write),
        .uart_tx_fifo_full (uart_tx_fifo_full),
        .grant             (grant),
        .busy              (busy),
        .overlong_error    (overlong_error),
        .stall_error       (stall_error)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] d;
        logic       l;
    } byte_t;

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] d;
    } exp_t;

    byte_t rq [N][$];
    exp_t  expq[$];
    int    wr_cyc[$];
    exp_t  e;
    logic [N-1:0] acc;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_wr = 0;
    int n_ovl = 0;
    int n_stl = 0;
    int ovl_gap = 0;
    int stl_gap = 0;
    int last_wr_cyc = 0;
    int base;

    function automatic void chk(input string name,
                                input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Monitor: every FIFO write pops one expected byte.
    always @(negedge clock) begin
        if (!reset) begin
            if (overlong_error) begin
                n_ovl++;
                ovl_gap = cyc - last_wr_cyc;
            end
            if (stall_error) begin
                n_stl++;
                stl_gap = cyc - last_wr_cyc;
            end
            if (uart_tx_fifo_write) begin
                chk("err_with_write", {30'b0, overlong_error, stall_error}, 0);
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write actual=%0h required=none",
                             uart_tx_fifo_data);
                end else begin
                    e = expq.pop_front();
                    chk("wr_data", 32'(uart_tx_fifo_data), 32'(e.d));
                    chk("wr_grant", 32'(grant), 32'(1) << e.id);
                    chk("wr_ready", 32'(req_ready), 32'(1) << e.id);
                end
                wr_cyc.push_back(cyc);
                last_wr_cyc = cyc;
                n_wr++;
            end
        end
    end

    // Requester drivers: present queue heads, pop on observed accept.
    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clock);
            acc = req_valid & req_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                if (rq[i].size() > 0) begin
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = rq[i][0].d;
                    req_last[i]       = rq[i][0].l;
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    task automatic push_msg(input int id, input logic [7:0] b0,
                            input int n, input bit last_end);
        for (int k = 0; k < n; k++) begin
            rq[id].push_back(byte_t'{d: 8'(b0 + k),
                                     l: (last_end && k == n - 1)});
        end
    endtask

    task automatic expect_bytes(input int id, input logic [7:0] b0,
                                input int n);
        for (int k = 0; k < n; k++) begin
            expq.push_back(exp_t'{id: 2'(id), d: 8'(b0 + k)});
        end
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clock);
            #1;
            if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0
                && expq.size() == 0 && !busy) done = 1'b1;
        end
        chk(name, 32'(done), 1);
    endtask

    task automatic wait_wr(input int target, input int budget,
                           input string name);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            @(negedge clock);
            #1;
            if (n_wr >= target) done = 1'b1;
        end
        chk(name, 32'(done), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Reset state
        @(negedge clock);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_write", 32'(uart_tx_fifo_write), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_data", 32'(uart_tx_fifo_data), 0);
        chk("rst_errs", {30'b0, overlong_error, stall_error}, 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Two-byte message from requester 0
        wr_cyc.delete();
        push_msg(0, 8'h4F, 1, 0);
        push_msg(0, 8'h6B, 1, 1);
        expq.push_back(exp_t'{id: 2'd0, d: 8'h4F});
        expq.push_back(exp_t'{id: 2'd0, d: 8'h6B});
        wait_idle(50, "t1_drain");
        chk("t1_nwr", 32'(wr_cyc.size()), 2);
        if (wr_cyc.size() == 2) chk("t1_gap", 32'(wr_cyc[1] - wr_cyc[0]), 1);
        chk("t1_grant_idle", 32'(grant), 0);

        // All three request together after reset: order 0,1,2
        do_reset();
        wr_cyc.delete();
        push_msg(0, 8'h10, 2, 1);
        push_msg(1, 8'h20, 2, 1);
        push_msg(2, 8'h30, 2, 1);
        expect_bytes(0, 8'h10, 2);
        expect_bytes(1, 8'h20, 2);
        expect_bytes(2, 8'h30, 2);
        wait_idle(60, "t2_drain");
        chk("t2_nwr", 32'(wr_cyc.size()), 6);
        if (wr_cyc.size() == 6) begin
            for (int k = 0; k < 5; k++) begin
                chk("t2_gap", 32'(wr_cyc[k+1] - wr_cyc[k]),
                    (k % 2 == 0) ? 32'd1 : 32'd2);
            end
        end

        // FIFO full for 5 cycles mid-message from requester 1
        wr_cyc.delete();
        base = n_wr;
        push_msg(1, 8'h40, 3, 1);
        expect_bytes(1, 8'h40, 3);
        wait_wr(base + 1, 20, "t3_first_wr");
        @(posedge clock);
        #1;
        uart_tx_fifo_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk("t3_full_write", 32'(uart_tx_fifo_write), 0);
            chk("t3_full_ready", 32'(req_ready), 0);
            chk("t3_full_busy", 32'(busy), 1);
            @(posedge clock);
        end
        #1;
        uart_tx_fifo_full = 1'b0;
        wait_idle(50, "t3_drain");
        chk("t3_nwr", 32'(wr_cyc.size()), 3);
        if (wr_cyc.size() == 3) begin
            chk("t3_resume_gap", 32'(wr_cyc[1] - wr_cyc[0]), 6);
            chk("t3_next_gap", 32'(wr_cyc[2] - wr_cyc[1]), 1);
        end
        chk("t3_no_stall", 32'(n_stl), 0);

        // Overlong: req2 streams 20 bytes, forced release after 16
        wr_cyc.delete();
        n_ovl = 0;
        push_msg(2, 8'hA0, 20, 1);
        push_msg(0, 8'h50, 2, 1);
        expect_bytes(2, 8'hA0, 16);
        expect_bytes(0, 8'h50, 2);
        expect_bytes(2, 8'hB0, 4);
        wait_idle(200, "t4_drain");
        chk("t4_ovl_count", 32'(n_ovl), 1);
        chk("t4_ovl_gap", 32'(ovl_gap), 1);
        chk("t4_no_stall", 32'(n_stl), 0);
        if (wr_cyc.size() == 22)
            chk("t4_rearb_gap", 32'(wr_cyc[16] - wr_cyc[15]), 2);
        else
            chk("t4_nwr", 32'(wr_cyc.size()), 22);

        // Stall: req0 sends one byte and goes quiet, req1 waits
        wr_cyc.delete();
        n_stl = 0;
        push_msg(0, 8'h60, 1, 0);
        push_msg(1, 8'h70, 2, 1);
        expect_bytes(0, 8'h60, 1);
        expect_bytes(1, 8'h70, 2);
        wait_idle(300, "t5_drain");
        chk("t5_stall_count", 32'(n_stl), 1);
        chk("t5_stall_gap", 32'(stl_gap), 65);
        chk("t5_no_ovl", 32'(n_ovl), 1);
        if (wr_cyc.size() == 3)
            chk("t5_next_gap", 32'(wr_cyc[1] - wr_cyc[0]), 66);
        else
            chk("t5_nwr", 32'(wr_cyc.size()), 3);

        // Asynchronous reset mid-message
        base = n_wr;
        push_msg(1, 8'hD0, 5, 1);
        expect_bytes(1, 8'hD0, 5);
        wait_wr(base + 1, 20, "t6_first_wr");
        @(posedge clock);
        #3;
        chk("t6_pre_write", 32'(uart_tx_fifo_write), 1);
        reset = 1'b1;
        for (int i = 0; i < N; i++) rq[i].delete();
        expq.delete();
        #1;
        chk("t6_async_grant", 32'(grant), 0);
        chk("t6_async_write", 32'(uart_tx_fifo_write), 0);
        chk("t6_async_busy", 32'(busy), 0);
        chk("t6_async_ready", 32'(req_ready), 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        wr_cyc.delete();
        push_msg(0, 8'h80, 1, 1);
        push_msg(1, 8'h90, 1, 1);
        push_msg(2, 8'hC5, 1, 1);
        expect_bytes(0, 8'h80, 1);
        expect_bytes(1, 8'h90, 1);
        expect_bytes(2, 8'hC5, 1);
        wait_idle(50, "t6_drain");
        chk("t6_nwr", 32'(wr_cyc.size()), 3);

        @(negedge clock);
        chk("final_grant", 32'(grant), 0);
        chk("final_busy", 32'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmit FIFO write port between NUM_REQ byte-stream requesters, e.g. the command controller's "Ok"/"Er" answers, a status reporter and a debug echo.
- Grants are round-robin and message-atomic: once granted, a requester owns the FIFO until it delivers its last byte.
- Watchdogs force release of the grant on overlong or stalled messages.
- Sits between the requester blocks and the UART TX FIFO.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
MAX_MSG_LEN, 16, maximum bytes per message before forced release (1..255)
STALL_LIMIT, 64, consecutive cycles the owner may hold req_valid low mid-message before forced release (1..255)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  requester i has a byte on req_data
req_data  in  8*NUM_REQ  packed bytes; requester i on [8i+7:8i]
req_last  in  NUM_REQ  current byte of requester i ends its message
req_ready  out  NUM_REQ  byte of requester i accepted this cycle
uart_tx_fifo_data  out  8  byte to the TX FIFO
uart_tx_fifo_write  out  1  TX FIFO write strobe
uart_tx_fifo_full  in  1  TX FIFO full
grant  out  NUM_REQ  one-hot current owner; all zero when idle
busy  out  1  a message is in progress
overlong_error  out  1  one-cycle pulse on MAX_MSG_LEN forced release
stall_error  out  1  one-cycle pulse on STALL_LIMIT forced release

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE; grant=0; busy=0; both error pulses 0.
  - Byte and stall counters 0; last_owner=NUM_REQ-1, so requester 0 wins first.
  - Write, ready and data outputs are combinational from grant, so they read 0 while in reset.
- States:
  - IDLE:
    - If any req_valid is high, pick the first set index scanning cyclically from last_owner+1.
    - Register that index into grant and go to XFER next cycle.
    - With no request, remain in IDLE.
    - Arbitration costs exactly one cycle between messages.
  - XFER:
    - Let g be the granted index.
    - req_ready[g] = req_valid[g] & ~uart_tx_fifo_full. All other req_ready bits are 0.
    - uart_tx_fifo_write = req_ready[g].
    - uart_tx_fifo_data = req_data[g], muxed combinationally and valid only when write=1; it is 0 when grant is 0.
    - Accept (valid&ready) with req_last[g]=1: go to IDLE; grant<=0; last_owner<=g; counters cleared.
    - Accept without last: byte_cnt+1. Reaching MAX_MSG_LEN releases the grant: go to IDLE, last_owner<=g, overlong_error pulses the following cycle. The requester's remaining bytes are treated as a new message on its next grant.
    - req_valid[g]=0: stall_cnt+1, and any accept clears it. Reaching STALL_LIMIT releases the grant: go to IDLE, last_owner<=g, stall_error pulses.
    - uart_tx_fifo_full=1 with req_valid[g]=1: no write, no ready. The FIFO is backpressuring, so this is not a stall and stall_cnt holds.
- Non-owner requests during XFER wait; requesters must hold req_valid and req_data stable until ready.
- busy = (state==XFER).
- Message of one byte with last: one XFER cycle, then IDLE.
- Back-to-back messages from one requester while others request: round-robin, so the others are served first.
- Sole requester repeatedly: it is re-granted after the one IDLE cycle.
- Error pulses never coincide with a write in the same cycle, and at most one error pulses per release.
- Counters sized ceil(log2(limit+1)) bits; no wrap is possible because release occurs at the limit.

Test Plan:
- Req0 sends 0x4F then 0x6B+last with FIFO not full → writes 0x4F, 0x6B on consecutive cycles; grant=001 for 2 cycles; then IDLE.
- Req0, req1, req2 each hold a 2-byte message from the same cycle → service order 0,1,2; each message contiguous; one idle cycle between messages; no interleaving.
- Req1 mid-message, uart_tx_fifo_full high for 5 cycles → no writes, req_ready=0, stall_cnt stays 0; transfer resumes the cycle after full drops.
- Req2 streams 20 bytes without last, MAX_MSG_LEN=16 → 16 writes; overlong_error one pulse; req0 (waiting) granted next; req2 resumes later.
- Req0 sends 1 byte without last, then drops valid → stall_error after 64 low cycles; grant released; pending req1 then served.
- Reset asserted asynchronously mid-message → grant, write and busy go to 0 immediately; after release, req0 has priority over req1 and req2 when all request together.
